uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_START_TIMEOUT = 64;
    localparam int DEF_HOLD_TIMEOUT  = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } arb_state_t;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after the
// pointer, wrapping around, and returns it one-hot.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] sel;

    // Scan from the pointer position; the first asserted request wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = IDX_W'((int'(pointer) + k) % NUM_REQ);
            if (!found && req[sel]) begin
                winner[sel] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters. A requester owns the
// transmitter for a whole message (until the byte flagged last), so bytes of
// different messages never interleave.
//
// Handshake: a byte moves on a clk edge where req_valid[i] and req_ready[i]
// are both 1. req_ready is only raised in ISSUE, only for the owner, and only
// while that owner's req_valid is 1; a requester must hold req_valid, req_data
// and req_last steady until that edge and may drop req_valid at any time
// before it without side effects.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int HOLD_TIMEOUT  = DEF_HOLD_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 err_timeout,
    output logic [2:0]           fsm_state
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int CNT_MAX = (START_TIMEOUT > HOLD_TIMEOUT) ? START_TIMEOUT : HOLD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] START_LIMIT = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT  = CNT_W'(HOLD_TIMEOUT - 1);

    arb_state_t         state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   ptr, ptr_next, ptr_adv;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               tx_start_next;
    logic [7:0]         tx_data_next;
    logic               last_q, last_next;
    logic               err_next;
    logic               sel_valid, sel_last;
    logic [7:0]         sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .pointer (ptr),
        .winner  (win)
    );

    // Route the current owner's request lines and compute the pointer value
    // that follows it (the index after the owner, wrapping).
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ptr_adv   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_data  = req_data[k*8 +: 8];
                ptr_adv   = (k == NUM_REQ - 1) ? '0 : IDX_W'(k + 1);
            end
        end
    end

    // Accept strobe: only the owner, only in ISSUE, only while it offers a byte.
    always_comb begin
        req_ready = '0;
        if (state == ISSUE) begin
            req_ready = grant & req_valid;
        end
    end

    assign fsm_state = state;

    // Next-state logic; the shared timeout counter restarts on every state change.
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        ptr_next      = ptr;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        last_next     = last_q;
        err_next      = err_timeout;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = win;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_valid) begin
                    tx_data_next  = sel_data;
                    last_next     = sel_last;
                    tx_start_next = 1'b1;
                    state_next    = WAIT_BUSY;
                end else begin
                    state_next = HOLD;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == START_LIMIT) begin
                    err_next   = 1'b1;
                    grant_next = '0;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_next = '0;
                        ptr_next   = ptr_adv;
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sel_valid) begin
                    state_next = ISSUE;
                end else if (cnt == HOLD_LIMIT) begin
                    grant_next = '0;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == WAIT_BUSY || state == HOLD) begin
            cnt_next = cnt + CNT_W'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            last_q      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            ptr         <= ptr_next;
            cnt         <= cnt_next;
            tx_start    <= tx_start_next;
            tx_data     <= tx_data_next;
            last_q      <= last_next;
            err_timeout <= err_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing scenarios plus randomized
// message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           err_timeout;
    logic [2:0]     fsm_state;

    int total = 0;
    int bad   = 0;

    // clock / reset infrastructure
    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .err_timeout (err_timeout),
        .fsm_state   (fsm_state)
    );

    // sources: per-requester byte lists, bit 8 = last flag
    logic [8:0] src_mem [N][16];
    int         src_len [N];
    int         src_pos [N];
    int         gap     [N];
    bit         uart_en = 1'b1;

    // scoreboard: {owner index, byte}
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         start_cnt = 0;
    int         viol_cnt  = 0;

    function automatic logic [1:0] owner_of(input logic [N-1:0] g);
        owner_of = 2'd0;
        for (int k = 0; k < N; k++) if (g[k]) owner_of = 2'(k);
    endfunction

    // monitor: record every start pulse and accept-strobe rule breaks
    always @(negedge clk) begin
        if (tx_start) begin
            obs_q.push_back({owner_of(grant), tx_data});
            start_cnt++;
        end
        if ($countones(req_ready) > 1) viol_cnt++;
        if (req_ready != '0 && fsm_state != ISSUE) viol_cnt++;
        if ((req_ready & ~req_valid) != '0) viol_cnt++;
    end

    // uart_tx stand-in: busy rises a few cycles after a start, then falls
    task automatic uart_model();
        forever begin
            @(negedge clk);
            if (tx_start && uart_en) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    endtask

    task automatic clear_sources();
        for (int r = 0; r < N; r++) begin
            src_len[r] = 0;
            src_pos[r] = 0;
            gap[r]     = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
        rst = 1'b1;
        clear_sources();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (fsm_state == IDLE && !tx_busy && grant == '0) break;
            @(negedge clk);
        end
    endtask

    task automatic add_byte(input int r, input logic lst, input logic [7:0] b);
        src_mem[r][src_len[r]] = {lst, b};
        src_len[r]++;
    endtask

    // driver: presents source bytes, random gaps inside a message only
    task automatic run_traffic(input int budget);
        logic [N-1:0] acc;
        int  cyc;
        bit  done;
        acc  = '0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int r = 0; r < N; r++) begin
                if (acc[r]) begin
                    gap[r] = src_mem[r][src_pos[r]][8] ? 0 : int'($urandom_range(0, 3));
                    src_pos[r]++;
                end
            end
            done = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (gap[r] > 0) begin
                    gap[r]--;
                    req_valid[r] = 1'b0;
                end else if (src_pos[r] < src_len[r]) begin
                    req_valid[r]        = 1'b1;
                    req_last[r]         = src_mem[r][src_pos[r]][8];
                    req_data[r*8 +: 8]  = src_mem[r][src_pos[r]][7:0];
                end else begin
                    req_valid[r] = 1'b0;
                end
                if (src_pos[r] < src_len[r]) done = 1'b0;
            end
            #1 acc = req_ready;
            if (fsm_state != IDLE || tx_busy) done = 1'b0;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL traffic_drain: finished=%0d required=1 after %0d cycles", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (grant !== 4'b0000)   begin bad++; $display("FAIL rst_grant: got=%b want=0000", grant); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got=%b want=0000", req_ready); end
        total++; if (tx_start !== 1'b0)   begin bad++; $display("FAIL rst_tx_start: got=%b want=0", tx_start); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_tx_data: got=%h want=00", tx_data); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got=%b want=0", err_timeout); end
        total++; if (fsm_state !== IDLE)  begin bad++; $display("FAIL rst_state: got=%0d want=%0d", fsm_state, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        bit unstable;
        int n;
        do_reset();
        unstable = 1'b0;
        req_valid[0]   = 1'b1;
        req_last[0]    = 1'b1;
        req_data[7:0]  = 8'hA5;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got=%b want=0001", req_ready); end
        total++; if (grant !== 4'b0001)     begin bad++; $display("FAIL single_grant: got=%b want=0001", grant); end
        @(negedge clk);
        req_valid = '0;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_latency: tx_start=%b want=1 two cycles after valid", tx_start); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got=%h want=a5", tx_data); end
        n = 0;
        while (grant !== 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
            if (grant !== 4'b0000 && tx_data !== 8'hA5) unstable = 1'b1;
        end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release: grant=%b want=0000", grant); end
        total++; if (tx_busy !== 1'b0)  begin bad++; $display("FAIL single_release_busy: tx_busy=%b want=0", tx_busy); end
        total++; if (unstable)          begin bad++; $display("FAIL single_data_stable: changed=1 want=0"); end
    endtask

    task automatic test_contention();
        int base;
        logic [7:0] b [5];
        do_reset();
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
        add_byte(0, 1'b1, b[0]);
        add_byte(1, 1'b1, b[1]);
        add_byte(2, 1'b1, b[2]);
        add_byte(3, 1'b1, b[3]);
        add_byte(0, 1'b1, b[4]);
        exp_q.delete();
        exp_q.push_back({2'd0, b[0]});
        exp_q.push_back({2'd1, b[1]});
        exp_q.push_back({2'd2, b[2]});
        exp_q.push_back({2'd3, b[3]});
        exp_q.push_back({2'd0, b[4]});
        base = obs_q.size();
        run_traffic(600);
        total++;
        if (obs_q.size() - base !== exp_q.size()) begin
            bad++; $display("FAIL contention_count: got=%0d want=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++;
            if (obs_q[base+i] !== exp_q[i]) begin
                bad++; $display("FAIL contention_order[%0d]: got=%h want=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_message_lock();
        int base;
        logic [7:0] other;
        do_reset();
        other = 8'($urandom_range(0, 255));
        add_byte(1, 1'b0, 8'h01);
        add_byte(1, 1'b0, 8'h02);
        add_byte(1, 1'b1, 8'h03);
        add_byte(2, 1'b1, other);
        exp_q.delete();
        exp_q.push_back({2'd1, 8'h01});
        exp_q.push_back({2'd1, 8'h02});
        exp_q.push_back({2'd1, 8'h03});
        exp_q.push_back({2'd2, other});
        base = obs_q.size();
        run_traffic(600);
        total++;
        if (obs_q.size() - base !== exp_q.size()) begin
            bad++; $display("FAIL lock_count: got=%0d want=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++;
            if (obs_q[base+i] !== exp_q[i]) begin
                bad++; $display("FAIL lock_order[%0d]: got=%h want=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_timeout();
        int n;
        do_reset();
        uart_en = 1'b0;
        req_valid       = 4'b0011;
        req_last        = 4'b0011;
        req_data[7:0]   = 8'h11;
        req_data[15:8]  = 8'h22;
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        total++; if (tx_start !== 1'b1)  begin bad++; $display("FAIL st_first_start: tx_start=%b want=1", tx_start); end
        total++; if (grant !== 4'b0001)  begin bad++; $display("FAIL st_first_owner: got=%b want=0001", grant); end
        req_valid[0] = 1'b0;
        n = 0;
        while (!err_timeout && n < 100) begin @(negedge clk); n++; end
        total++; if (n !== 64)           begin bad++; $display("FAIL st_latency: got=%0d want=64", n); end
        total++; if (grant !== 4'b0000)  begin bad++; $display("FAIL st_release: grant=%b want=0000", grant); end
        total++; if (fsm_state !== IDLE) begin bad++; $display("FAIL st_idle: state=%0d want=%0d", fsm_state, IDLE); end
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        total++; if (grant !== 4'b0010)  begin bad++; $display("FAIL st_next_owner: got=%b want=0010", grant); end
        total++; if (tx_data !== 8'h22)  begin bad++; $display("FAIL st_next_data: got=%h want=22", tx_data); end
        req_valid[1] = 1'b0;
        repeat (70) @(negedge clk);
        uart_en = 1'b1;
        req_valid[2]     = 1'b1;
        req_last[2]      = 1'b1;
        req_data[23:16]  = 8'h33;
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        req_valid[2] = 1'b0;
        wait_idle();
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL st_sticky: err=%b want=1", err_timeout); end
        do_reset();
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL st_clear_on_rst: err=%b want=0", err_timeout); end
    endtask

    task automatic test_hold_timeout();
        int n;
        do_reset();
        req_valid[3]     = 1'b1;
        req_last[3]      = 1'b0;
        req_data[31:24]  = 8'h3C;
        n = 0;
        while (!req_ready[3] && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[3]   = 1'b0;
        req_valid[0]   = 1'b1;
        req_last[0]    = 1'b1;
        req_data[7:0]  = 8'h5A;
        n = 0;
        while (fsm_state !== HOLD && n < 50) begin @(negedge clk); n++; end
        total++; if (fsm_state !== HOLD) begin bad++; $display("FAIL hold_entry: state=%0d want=%0d", fsm_state, HOLD); end
        n = 0;
        while (grant === 4'b1000 && n < 1100) begin @(negedge clk); n++; end
        total++; if (n !== 1024)           begin bad++; $display("FAIL hold_latency: got=%0d want=1024", n); end
        total++; if (grant !== 4'b0000)    begin bad++; $display("FAIL hold_release: grant=%b want=0000", grant); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL hold_no_err: err=%b want=0", err_timeout); end
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        total++; if (grant !== 4'b0001)    begin bad++; $display("FAIL hold_next_owner: got=%b want=0001", grant); end
        total++; if (tx_data !== 8'h5A)    begin bad++; $display("FAIL hold_next_data: got=%h want=5a", tx_data); end
        req_valid[0] = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int n;
        int base;
        do_reset();
        req_valid[2]     = 1'b1;
        req_last[2]      = 1'b0;
        req_data[23:16]  = 8'h9C;
        n = 0;
        while (fsm_state !== WAIT_DONE && n < 50) begin @(negedge clk); n++; end
        total++; if (fsm_state !== WAIT_DONE) begin bad++; $display("FAIL mid_reach: state=%0d want=%0d", fsm_state, WAIT_DONE); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (grant !== 4'b0000)     begin bad++; $display("FAIL mid_grant: got=%b want=0000", grant); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready: got=%b want=0000", req_ready); end
        total++; if (tx_start !== 1'b0)     begin bad++; $display("FAIL mid_tx_start: got=%b want=0", tx_start); end
        total++; if (tx_data !== 8'h00)     begin bad++; $display("FAIL mid_tx_data: got=%h want=00", tx_data); end
        total++; if (fsm_state !== IDLE)    begin bad++; $display("FAIL mid_state: got=%0d want=%0d", fsm_state, IDLE); end
        rst = 1'b0;
        req_valid = '0;
        base = start_cnt;
        repeat (40) @(negedge clk);
        total++; if (start_cnt !== base)    begin bad++; $display("FAIL mid_no_start: starts=%0d want=0", start_cnt - base); end
        req_valid[1]    = 1'b1;
        req_last[1]     = 1'b1;
        req_data[15:8]  = 8'h44;
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        total++; if (tx_data !== 8'h44)     begin bad++; $display("FAIL mid_new_req: tx_data=%h want=44", tx_data); end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_random();
        int base;
        int vbase;
        int ptr;
        int who;
        int pos [N];
        int v;
        int len;
        bit lst;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int r = 0; r < N; r++) begin
                for (int m = int'($urandom_range(0, 3)); m > 0; m--) begin
                    len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) begin
                        v = int'($urandom_range(0, 255));
                        add_byte(r, (b == len - 1), v[7:0]);
                    end
                end
            end
            // reference: whole messages served round-robin, pointer after last owner
            exp_q.delete();
            for (int r = 0; r < N; r++) pos[r] = 0;
            ptr = 0;
            forever begin
                who = -1;
                for (int k = 0; k < N; k++)
                    if (who < 0 && pos[(ptr + k) % N] < src_len[(ptr + k) % N]) who = (ptr + k) % N;
                if (who < 0) break;
                lst = 1'b0;
                while (!lst) begin
                    exp_q.push_back({2'(who), src_mem[who][pos[who]][7:0]});
                    lst = src_mem[who][pos[who]][8];
                    pos[who]++;
                end
                ptr = (who + 1) % N;
            end
            base  = obs_q.size();
            vbase = viol_cnt;
            run_traffic(3000);
            total++;
            if (obs_q.size() - base !== exp_q.size()) begin
                bad++; $display("FAIL rand_count[%0d]: got=%0d want=%0d", round, obs_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
                total++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand_order[%0d][%0d]: got=%h want=%h", round, i, obs_q[base+i], exp_q[i]);
                end
            end
            total++;
            if (viol_cnt !== vbase) begin
                bad++; $display("FAIL rand_ready_rules[%0d]: violations=%0d want=0", round, viol_cnt - vbase);
            end
        end
    endtask

    task automatic test_ready_rules();
        total++;
        if (viol_cnt !== 0) begin
            bad++; $display("FAIL ready_rules: violations=%0d want=0", viol_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        fork
            uart_model();
        join_none
        test_reset();
        test_single_byte();
        test_contention();
        test_message_lock();
        test_start_timeout();
        test_hold_timeout();
        test_reset_mid();
        test_random();
        test_ready_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
